// File: rtl/mem_read_arbiter.sv
// Two-requester (IFU=0, LSU=1) round-robin read arbiter onto one single-beat read port.
// Latency: m_arvalid one cycle after upstream accept; R channel is passed through combinationally.
// Backpressure: one transaction in flight; s_arready stays low until the R handshake retires it.
module mem_read_arbiter #(
    parameter int ADDR_WIDTH = 32,  // XLEN
    parameter int DATA_WIDTH = 64,  // ACE_XDATA_WIDTH
    parameter int RESP_WIDTH = 2    // ACE_RRESP_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              s_arvalid,
    output logic [1:0]              s_arready,
    input  logic [2*ADDR_WIDTH-1:0] s_araddr,
    output logic [1:0]              s_rvalid,
    input  logic [1:0]              s_rready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [RESP_WIDTH-1:0]   s_rresp,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic                    m_arid,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [RESP_WIDTH-1:0]   m_rresp,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    logic   last_q;
    logic   grant_q;
    logic   any_req;
    logic   winner;

    assign any_req = |s_arvalid;
    // On a tie the requester that was not served last wins; a lone requester always wins.
    assign winner  = (s_arvalid == 2'b11) ? ~last_q : s_arvalid[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            m_araddr  <= '0;
            m_arid    <= 1'b0;
            m_arvalid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        m_araddr  <= winner ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                            : s_araddr[ADDR_WIDTH-1:0];
                        m_arid    <= winner;
                        grant_q   <= winner;
                        m_arvalid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (m_rvalid && s_rready[grant_q]) begin
                        last_q <= grant_q;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    m_arvalid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // rst_n gates the accept so it drops immediately while reset is held.
    always_comb begin
        s_arready = 2'b00;
        s_rvalid  = 2'b00;
        m_rready  = 1'b0;
        if (rst_n && state == IDLE && any_req) begin
            s_arready[winner] = 1'b1;
        end
        if (state == DATA) begin
            s_rvalid[grant_q] = m_rvalid;
            m_rready          = s_rready[grant_q];
        end
    end

    assign s_rdata = m_rdata;
    assign s_rresp = m_rresp;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized bench for mem_read_arbiter: per-requester scoreboards plus a round-robin reference model.
module tb_mem_read_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int RW = 2;

    logic          clk;
    logic          rst_n;
    logic [1:0]    s_arvalid;
    logic [1:0]    s_arready;
    logic [2*AW-1:0] s_araddr;
    logic [1:0]    s_rvalid;
    logic [1:0]    s_rready;
    logic [DW-1:0] s_rdata;
    logic [RW-1:0] s_rresp;
    logic          m_arvalid;
    logic          m_arready;
    logic [AW-1:0] m_araddr;
    logic          m_arid;
    logic          m_rvalid;
    logic          m_rready;
    logic [DW-1:0] m_rdata;
    logic [RW-1:0] m_rresp;
    logic          busy;

    mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk = 0;
    int n_pass = 0;

    // stimulus knobs (percent probabilities); rd_fixed < 0 means random read latency
    int p_new0 = 0, p_new1 = 0, p_ar = 100, p_rr0 = 100, p_rr1 = 100, p_noise = 0, rd_fixed = 2;
    int rd_wait = 0;

    // reference model state
    int            ph = 0;          // 0 idle, 1 address issued, 2 awaiting data
    logic          last_m = 1'b1;
    logic          cur_id = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic          slave_has = 1'b0;
    logic [AW-1:0] slave_addr = '0;
    logic [1:0]    acc = 2'b00;
    logic          prev_busy = 1'b0;
    int            busy_rises = 0;
    logic [AW:0]   glog[$];
    logic [DW+RW-1:0] exp_d0[$];
    logic [DW+RW-1:0] exp_d1[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return {~a, a ^ 32'h5A5A_C3C3};
    endfunction

    function automatic logic [RW-1:0] mem_resp(input logic [AW-1:0] a);
        return a[3:2];
    endfunction

    function automatic bit roll(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    task automatic issue(input int i, input logic [AW-1:0] a);
        if (i == 0) begin
            s_arvalid[0]     = 1'b1;
            s_araddr[AW-1:0] = a;
            exp_d0.push_back({mem_data(a), mem_resp(a)});
        end else begin
            s_arvalid[1]        = 1'b1;
            s_araddr[2*AW-1:AW] = a;
            exp_d1.push_back({mem_data(a), mem_resp(a)});
        end
    endtask

    // One clock of stimulus: requesters, upstream R ready, downstream slave.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (acc[i]) s_arvalid[i] = 1'b0;
        if (rst_n) begin
            if (!s_arvalid[0] && roll(p_new0)) issue(0, $urandom);
            if (!s_arvalid[1] && roll(p_new1)) issue(1, $urandom);
        end
        s_rready[0] = roll(p_rr0);
        s_rready[1] = roll(p_rr1);
        m_arready   = roll(p_ar);
        if (slave_has) begin
            if (rd_wait > 0) begin
                rd_wait--;
                m_rvalid = 1'b0;
            end else begin
                m_rvalid = 1'b1;
                m_rdata  = mem_data(slave_addr);
                m_rresp  = mem_resp(slave_addr);
            end
        end else begin
            rd_wait  = (rd_fixed >= 0) ? rd_fixed : int'($urandom_range(0, 4));
            m_rvalid = roll(p_noise);
            m_rdata  = {$urandom, $urandom};
            m_rresp  = RW'($urandom);
        end
    endtask

    task automatic wait_idle(input string name, input int bound);
        int  n = 0;
        bit  done;
        done = 0;
        while (n < bound) begin
            done = (ph == 0) && (s_arvalid == 2'b00) && (exp_d0.size() == 0) && (exp_d1.size() == 0);
            if (done) break;
            step();
            n++;
        end
        chk(name, done, 1);
    endtask

    task automatic wait_phase(input string name, input int p, input int bound);
        int n = 0;
        while (ph != p && n < bound) begin
            step();
            n++;
        end
        chk(name, ph == p, 1);
    endtask

    // Monitor: reference model + scoreboard pop, sampled on the falling edge.
    initial begin
        logic          w;
        logic [1:0]    exp_v;
        logic [DW+RW-1:0] e;
        forever begin
            @(negedge clk);
            acc = 2'b00;
            chk("rdata_pass", {s_rdata, s_rresp}, {m_rdata, m_rresp});
            if (!rst_n) begin
                chk("rst_ctl", {s_arready, s_rvalid, m_arvalid, m_rready, busy, m_arid}, 8'h00);
                chk("rst_araddr", m_araddr, 0);
                ph = 0; last_m = 1'b1; slave_has = 1'b0; prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) busy_rises++;
                prev_busy = busy;
                chk("busy", busy, ph != 0);
                if (ph == 0) begin
                    chk("idle_arvalid", m_arvalid, 0);
                    chk("idle_rvalid", {s_rvalid, m_rready}, 3'b000);
                    if (s_arvalid != 2'b00) begin
                        if (s_arvalid[0] && s_arvalid[1]) w = (last_m == 1'b1) ? 1'b0 : 1'b1;
                        else if (s_arvalid[0]) w = 1'b0;
                        else w = 1'b1;
                        exp_v = 2'b00;
                        exp_v[w] = 1'b1;
                        chk("arb_grant", s_arready, exp_v);
                        cur_id   = w;
                        cur_addr = w ? s_araddr[2*AW-1:AW] : s_araddr[AW-1:0];
                        acc = exp_v;
                        ph  = 1;
                    end else begin
                        chk("idle_arready", s_arready, 2'b00);
                    end
                end else if (ph == 1) begin
                    chk("addr_arready", s_arready, 2'b00);
                    chk("addr_arvalid", m_arvalid, 1);
                    chk("addr_araddr", m_araddr, cur_addr);
                    chk("addr_arid", m_arid, cur_id);
                    chk("addr_rvalid", {s_rvalid, m_rready}, 3'b000);
                    if (m_arready) begin
                        glog.push_back({m_arid, m_araddr});
                        slave_addr = m_araddr;
                        slave_has  = 1'b1;
                        ph = 2;
                    end
                end else begin
                    chk("data_arready", s_arready, 2'b00);
                    chk("data_arvalid", m_arvalid, 0);
                    exp_v = 2'b00;
                    exp_v[cur_id] = m_rvalid;
                    chk("data_srvalid", s_rvalid, exp_v);
                    chk("data_mrready", m_rready, s_rready[cur_id]);
                    if (m_rvalid && s_rready[cur_id]) begin
                        if (cur_id == 1'b0 && exp_d0.size() > 0) begin
                            e = exp_d0.pop_front();
                            chk("rdata0", {s_rdata, s_rresp}, e);
                        end else if (cur_id == 1'b1 && exp_d1.size() > 0) begin
                            e = exp_d1.pop_front();
                            chk("rdata1", {s_rdata, s_rresp}, e);
                        end else begin
                            chk("r_unexpected", cur_id, ~cur_id);
                        end
                        last_m    = cur_id;
                        slave_has = 1'b0;
                        ph = 0;
                    end
                end
            end
        end
    end

    initial begin
        int b0;
        rst_n = 1'b0; s_arvalid = 2'b00; s_araddr = '0; s_rready = 2'b00;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // simultaneous requests from reset: 0 first, then 1
        glog.delete();
        step();
        issue(0, 32'h1000);
        issue(1, 32'h2000);
        wait_idle("a_done", 100);
        chk("a_cnt", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("a_g0", glog[0], {1'b0, 32'h0000_1000});
            chk("a_g1", glog[1], {1'b1, 32'h0000_2000});
        end

        // lone LSU requester three times
        b0 = busy_rises;
        for (int k = 0; k < 3; k++) begin
            step();
            issue(1, 32'h3000 + 32'(k * 16));
            wait_idle("b_done", 100);
        end
        chk("b_busy_pulses", busy_rises - b0, 3);

        // downstream AR stall
        p_ar = 0;
        step();
        issue(0, 32'h4440);
        wait_phase("c_addr", 1, 20);
        repeat (5) begin
            step();
            chk("c_arvalid", m_arvalid, 1);
            chk("c_araddr", m_araddr, 32'h4440);
        end
        p_ar = 100;
        wait_idle("c_done", 50);

        // upstream R stall with data pending
        p_rr0 = 0; rd_fixed = 0;
        step();
        issue(0, 32'h5550);
        wait_phase("d_data", 2, 20);
        repeat (3) begin
            step();
            chk("d_srvalid0", s_rvalid[0], 1);
            chk("d_srvalid1", s_rvalid[1], 0);
            chk("d_mrready", m_rready, 0);
            chk("d_busy", busy, 1);
        end
        p_rr0 = 100;
        wait_idle("d_done", 50);

        // reset in the middle of DATA
        p_rr0 = 0;
        step();
        issue(0, 32'h6660);
        wait_phase("e_data", 2, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("e_rst_ctl", {s_arready, s_rvalid, m_arvalid, m_rready, busy, m_arid}, 8'h00);
        chk("e_rst_araddr", m_araddr, 0);
        s_arvalid = 2'b00;
        exp_d0.delete();
        exp_d1.delete();
        step();
        step();
        rst_n = 1'b1;
        p_rr0 = 100; rd_fixed = 2;
        glog.delete();
        step();
        issue(0, 32'h7000);
        issue(1, 32'h8000);
        wait_idle("e_done", 100);
        chk("e_cnt", glog.size(), 2);
        if (glog.size() >= 1) chk("e_g0", glog[0], {1'b0, 32'h0000_7000});

        // stray m_rvalid while idle
        p_noise = 100;
        repeat (6) begin
            step();
            chk("f_mrready", m_rready, 0);
            chk("f_srvalid", s_rvalid, 2'b00);
            chk("f_busy", busy, 0);
        end

        // random traffic
        p_new0 = 35; p_new1 = 35; p_ar = 60; p_rr0 = 70; p_rr1 = 70; p_noise = 30; rd_fixed = -1;
        repeat (1500) step();
        p_new0 = 0; p_new1 = 0; p_ar = 100; p_rr0 = 100; p_rr1 = 100;
        wait_idle("drain", 300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
